// File: rtl/sprite_frame_ctrl.sv
// Avalon-MM register front end and frame scheduler for the sprite compositor.
// Shadow sprite registers are copied to the active set during vertical blank, one slot per cycle.
module sprite_frame_ctrl #(
    parameter int NUM_SPRITES = 6,
    parameter int X_W         = 11,
    parameter int Y_W         = 10,
    parameter int VACTIVE     = 480
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [8:0]                 address,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    input  logic [9:0]                 vcount,
    output logic [NUM_SPRITES*X_W-1:0] spr_x,
    output logic [NUM_SPRITES*Y_W-1:0] spr_y,
    output logic [NUM_SPRITES-1:0]     spr_en,
    output logic [15:0]                frame_count,
    output logic                       irq
);
    localparam int IDX_W = $clog2(NUM_SPRITES + 1);

    typedef enum logic [1:0] {IDLE, COMMIT, DONE} state_t;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [NUM_SPRITES-1:0][X_W-1:0]     sh_x_q, act_x_q;
    logic [NUM_SPRITES-1:0][Y_W-1:0]     sh_y_q, act_y_q;
    logic [NUM_SPRITES-1:0]              sh_en_q, act_en_q;
    logic                                pending_q, auto_q, irq_en_q, irq_q;
    logic [9:0]                          vcount_q;
    logic [15:0]                         frame_count_q;
    logic [31:0]                         readdata_q, rd_mux;

    logic       wr, rd, in_slot, frame_edge, start, busy, copy_slot, copy_mask;
    logic [4:0] slot_a;
    logic       unused_wdata;

    assign wr           = chipselect && write;
    assign rd           = chipselect && read;
    assign in_slot      = address < 9'(2 * NUM_SPRITES);
    assign slot_a       = address[5:1];
    assign unused_wdata = ^writedata;
    assign frame_edge   = (vcount == 10'(VACTIVE)) && (vcount_q != 10'(VACTIVE));
    assign busy         = (state_q != IDLE);
    assign copy_slot    = (state_q == COMMIT) && (idx_q != IDX_W'(NUM_SPRITES));
    assign copy_mask    = (state_q == COMMIT) && (idx_q == IDX_W'(NUM_SPRITES));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                // Edges arriving outside IDLE still count frames but never start a commit.
                if (frame_edge && (pending_q || auto_q)) begin
                    state_d = COMMIT;
                    idx_d   = '0;
                    start   = 1'b1;
                end
            end
            COMMIT: begin
                if (copy_mask) state_d = DONE;
                else           idx_d   = idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (in_slot) begin
            for (int k = 0; k < NUM_SPRITES; k++)
                if (slot_a == 5'(k))
                    rd_mux = address[0] ? 32'(sh_y_q[k]) : 32'(sh_x_q[k]);
        end else begin
            case (address)
                9'h040:  rd_mux = 32'(sh_en_q);
                9'h041:  rd_mux = {29'b0, irq_en_q, auto_q, pending_q};
                9'h042:  rd_mux = {frame_count_q, 13'b0, busy, irq_q, pending_q};
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            sh_x_q        <= '0;
            sh_y_q        <= '0;
            sh_en_q       <= '0;
            act_x_q       <= '0;
            act_y_q       <= '0;
            act_en_q      <= '0;
            pending_q     <= 1'b0;
            auto_q        <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
            vcount_q      <= '0;
            frame_count_q <= '0;
            readdata_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vcount_q <= vcount;
            if (frame_edge) frame_count_q <= frame_count_q + 16'd1;
            if (rd)         readdata_q    <= rd_mux;

            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (wr && in_slot && slot_a == 5'(k)) begin
                    if (address[0]) sh_y_q[k] <= writedata[Y_W-1:0];
                    else            sh_x_q[k] <= writedata[X_W-1:0];
                end
                // Copy sees the shadow as it stood before any same-cycle write.
                if (copy_slot && idx_q == IDX_W'(k)) begin
                    act_x_q[k] <= sh_x_q[k];
                    act_y_q[k] <= sh_y_q[k];
                end
            end
            if (wr && address == 9'h040) sh_en_q  <= writedata[NUM_SPRITES-1:0];
            if (copy_mask)               act_en_q <= sh_en_q;

            if (wr && address == 9'h041) begin
                auto_q   <= writedata[1];
                irq_en_q <= writedata[2];
            end
            if (wr && address == 9'h041 && writedata[0]) pending_q <= 1'b1;
            else if (start)                              pending_q <= 1'b0;

            if (state_q == DONE && irq_en_q)                     irq_q <= 1'b1;
            else if (wr && address == 9'h043 && writedata[0])    irq_q <= 1'b0;
        end
    end

    assign readdata    = readdata_q;
    assign spr_x       = act_x_q;
    assign spr_y       = act_y_q;
    assign spr_en      = act_en_q;
    assign frame_count = frame_count_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_sprite_frame_ctrl.sv
// Self-checking bench for sprite_frame_ctrl: register table, directed frame sequences, random ops vs a frame-level model.
module tb_sprite_frame_ctrl;
    localparam int N  = 6;
    localparam int XW = 11;
    localparam int YW = 10;

    logic          clk = 1'b0, reset = 1'b1;
    logic          chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [8:0]    address = '0;
    logic [31:0]   writedata = '0, readdata;
    logic [9:0]    vcount = '0;
    logic [N*XW-1:0] spr_x;
    logic [N*YW-1:0] spr_y;
    logic [N-1:0]  spr_en;
    logic [15:0]   frame_count;
    logic          irq;

    sprite_frame_ctrl #(.NUM_SPRITES(N), .X_W(XW), .Y_W(YW), .VACTIVE(480)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata), .vcount(vcount),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .frame_count(frame_count), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Frame-level model: shadow and active register files plus control bits.
    logic [XW-1:0] mx[N], ax[N];
    logic [YW-1:0] my[N], ay[N];
    logic [N-1:0]  men, aen;
    bit            pend, autom, irqen, irqm;
    int            fc;

    typedef struct { bit wr; logic [8:0] a; logic [31:0] d; logic [31:0] e; } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic avw(input logic [8:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic avr(input logic [8:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin mx[k] = '0; my[k] = '0; ax[k] = '0; ay[k] = '0; end
        men = '0; aen = '0; pend = 0; autom = 0; irqen = 0; irqm = 0; fc = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0; vcount = '0;
        tick(); tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic mwrite(input logic [8:0] a, input logic [31:0] d);
        if (a < 9'(2*N)) begin
            if (a[0]) my[int'(a >> 1)] = d[YW-1:0];
            else      mx[int'(a >> 1)] = d[XW-1:0];
        end else if (a == 9'h040) men = d[N-1:0];
        else if (a == 9'h041) begin pend = pend | d[0]; autom = d[1]; irqen = d[2]; end
        else if (a == 9'h043 && d[0]) irqm = 0;
        avw(a, d);
    endtask

    function automatic logic [31:0] exp_read(input logic [8:0] a);
        if (a < 9'(2*N)) return a[0] ? 32'(my[int'(a >> 1)]) : 32'(mx[int'(a >> 1)]);
        case (a)
            9'h040:  return 32'(men);
            9'h041:  return {29'b0, irqen, autom, pend};
            9'h042:  return {fc[15:0], 13'b0, 1'b0, irqm, pend};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [N*XW-1:0] px();
        logic [N*XW-1:0] r;
        for (int k = 0; k < N; k++) r[k*XW +: XW] = ax[k];
        return r;
    endfunction

    function automatic logic [N*YW-1:0] py();
        logic [N*YW-1:0] r;
        for (int k = 0; k < N; k++) r[k*YW +: YW] = ay[k];
        return r;
    endfunction

    task automatic snapshot();
        for (int k = 0; k < N; k++) begin ax[k] = mx[k]; ay[k] = my[k]; end
        aen = men; pend = 0;
        if (irqen) irqm = 1;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_spr_x"}, 128'(spr_x), 128'(px()));
        chk({tag, "_spr_y"}, 128'(spr_y), 128'(py()));
        chk({tag, "_spr_en"}, 128'(spr_en), 128'(aen));
        chk({tag, "_irq"}, 128'(irq), 128'(irqm));
        chk({tag, "_frame_count"}, 128'(frame_count), 128'(fc[15:0]));
    endtask

    // One frame: 479 -> 480, then stream STATUS reads to count busy cycles.
    task automatic do_frame(input string tag);
        bit c;
        int nb;
        vcount = 10'd479; tick();
        vcount = 10'd480; c = pend || autom; tick(); fc++;
        vcount = 10'($urandom_range(0, 479));
        chipselect = 1'b1; read = 1'b1; address = 9'h042; nb = 0;
        repeat (12) begin tick(); if (readdata[2]) nb++; end
        chipselect = 1'b0; read = 1'b0;
        chk({tag, "_busy_cycles"}, 128'(nb), c ? 128'(N + 2) : 128'(0));
        if (c) snapshot();
        chk_out(tag);
    endtask

    initial begin
        logic [31:0] rdv;
        logic [8:0]  ra;
        int          rises;
        bit          prev;

        tbl[0]  = '{1'b1, 9'h000, 32'hFFFF_FFFF, 32'h0};
        tbl[1]  = '{1'b0, 9'h000, 32'h0,         32'h0000_07FF};
        tbl[2]  = '{1'b1, 9'h00B, 32'hFFFF_FFFF, 32'h0};
        tbl[3]  = '{1'b0, 9'h00B, 32'h0,         32'h0000_03FF};
        tbl[4]  = '{1'b1, 9'h040, 32'hFFFF_FFFF, 32'h0};
        tbl[5]  = '{1'b0, 9'h040, 32'h0,         32'h0000_003F};
        tbl[6]  = '{1'b1, 9'h041, 32'h0000_0006, 32'h0};
        tbl[7]  = '{1'b0, 9'h041, 32'h0,         32'h0000_0006};
        tbl[8]  = '{1'b1, 9'h041, 32'h0000_0001, 32'h0};
        tbl[9]  = '{1'b0, 9'h042, 32'h0,         32'h0000_0001};
        tbl[10] = '{1'b1, 9'h00C, 32'h0000_0123, 32'h0};
        tbl[11] = '{1'b0, 9'h00C, 32'h0,         32'h0};
        tbl[12] = '{1'b0, 9'h1FF, 32'h0,         32'h0};
        tbl[13] = '{1'b1, 9'h041, 32'h0000_0000, 32'h0};
        tbl[14] = '{1'b0, 9'h041, 32'h0,         32'h0000_0001};

        do_reset();
        avr(9'h042, rdv);
        chk("reset_status", 128'(rdv), 128'(0));
        chk_out("reset");

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) avw(tbl[i].a, tbl[i].d);
            else begin
                avr(tbl[i].a, rdv);
                chk($sformatf("tbl%0d_rd_%0h", i, tbl[i].a), 128'(rdv), 128'(tbl[i].e));
            end
        end
        repeat (3) tick();
        chk("readdata_hold", 128'(readdata), 128'(32'h1));

        do_reset();
        mwrite(9'h000, 100); mwrite(9'h001, 260); mwrite(9'h040, 1);
        do_frame("nocommit");

        mwrite(9'h041, 5);
        do_frame("commit1");
        avr(9'h041, rdv);
        chk("commit1_ctrl", 128'(rdv), 128'(exp_read(9'h041)));
        mwrite(9'h043, 1);
        chk("irq_clear", 128'(irq), 128'(0));

        // Shadow writes landing mid-sweep: slot5 not yet copied, slot0 already copied.
        mwrite(9'h041, 1);
        vcount = 10'd479; tick();
        vcount = 10'd480; tick(); fc++;
        vcount = 10'd0;
        tick(); tick();
        avw(9'h00A, 500); mx[5] = 500;
        snapshot();
        avw(9'h000, 7); mx[0] = 7;
        repeat (10) tick();
        chk_out("midsweep");
        mwrite(9'h041, 1);
        do_frame("nextframe");

        // Auto mode with vcount held on the blank line for three lines' worth.
        mwrite(9'h041, 2);
        vcount = 10'd479; tick();
        vcount = 10'd480;
        chipselect = 1'b1; read = 1'b1; address = 9'h042; rises = 0; prev = 0;
        repeat (2400) begin
            tick();
            if (readdata[2] && !prev) rises++;
            prev = readdata[2];
        end
        chipselect = 1'b0; read = 1'b0; vcount = 10'd0;
        fc++; snapshot();
        chk("auto_commits", 128'(rises), 128'(1));
        chk_out("auto");
        mwrite(9'h041, 0);

        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    ra = ($urandom_range(0, 3) == 0) ? 9'h040 : 9'($urandom_range(0, 2*N-1));
                    mwrite(ra, $urandom);
                end
                3: begin
                    ra = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(12, 63)) : 9'($urandom_range(66, 511));
                    if (ra == 9'h043) ra = 9'h042;
                    mwrite(ra, $urandom);
                end
                4, 5: begin
                    case ($urandom_range(0, 3))
                        0:       ra = 9'($urandom_range(0, 2*N-1));
                        1:       ra = 9'($urandom_range(64, 67));
                        2:       ra = 9'($urandom_range(12, 63));
                        default: ra = 9'($urandom_range(68, 511));
                    endcase
                    avr(ra, rdv);
                    chk($sformatf("rand_rd_%0h", ra), 128'(rdv), 128'(exp_read(ra)));
                end
                6: mwrite(9'h041, 32'($urandom_range(0, 7)));
                7: mwrite(9'h043, 32'($urandom_range(0, 1)));
                default: do_frame("rand_frame");
            endcase
        end

        // Reset asserted while slot 3 is being copied.
        mwrite(9'h041, 5);
        vcount = 10'd479; tick();
        vcount = 10'd480; tick();
        vcount = 10'd0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_spr_x", 128'(spr_x), 128'(0));
        chk("rst_mid_spr_y", 128'(spr_y), 128'(0));
        chk("rst_mid_spr_en", 128'(spr_en), 128'(0));
        chk("rst_mid_fc", 128'(frame_count), 128'(0));
        tick();
        reset = 1'b0;
        model_clear();
        avr(9'h042, rdv);
        chk("rst_mid_status", 128'(rdv), 128'(0));
        for (int k = 0; k < 2*N; k++) mwrite(9'(k), $urandom);
        mwrite(9'h040, $urandom);
        mwrite(9'h041, 5);
        do_frame("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_frame_ctrl.md
Name: sprite_frame_ctrl

Overview:
- Avalon-MM register front end and frame scheduler for the sprite compositor.
- Software writes sprite positions and the enable mask into shadow registers.
- The block copies shadow to active registers only in vertical blank, so the compositor never sees a half-updated frame. It also keeps a frame counter and raises a commit-done interrupt.
- Sits between the HPS bridge and the sprite compositor; its vcount input comes from vga_counters.

Parameters:
NUM_SPRITES, 6, number of sprite slots (1..32)
X_W, 11, x coordinate width
Y_W, 10, y coordinate width
VACTIVE, 480, first vertical-blank line number

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high
chipselect  in  1  Avalon select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  9  Avalon word address
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, 1-cycle latency
vcount  in  10  current line from the VGA timing generator
spr_x  out  NUM_SPRITES*X_W  active x positions; slot k at [k*X_W +: X_W]
spr_y  out  NUM_SPRITES*Y_W  active y positions
spr_en  out  NUM_SPRITES  active enable mask
frame_count  out  16  frames since reset
irq  out  1  commit-done interrupt, level

Behaviour:
- Reset is asynchronous, active-high, on clock clk. It clears all outputs, all shadow registers, pending, auto, irq_en, the FSM state (IDLE) and readdata to 0.
- Register map (word address):
  - 2k: x shadow of slot k, writedata[X_W-1:0].
  - 2k+1: y shadow of slot k, writedata[Y_W-1:0].
  - 0x40: enable mask shadow, [NUM_SPRITES-1:0].
  - 0x41: CTRL. bit0 write-1 sets pending. bit1 auto. bit2 irq_en. Reads return {29'b0, irq_en, auto, pending}.
  - 0x42: STATUS (read-only) = {frame_count, 13'b0, busy, irq, pending}.
  - 0x43: write bit0 = 1 clears irq.
  - Unmapped reads return 0; unmapped writes are ignored. Shadow addresses are readable.
- Reads: readdata is registered, valid the cycle after chipselect&&read, and holds its value otherwise.
- Frame edge:
  - vcount_d is vcount registered.
  - frame_edge = (vcount == VACTIVE) && (vcount_d != VACTIVE). It fires exactly once per frame.
  - frame_count increments on every frame_edge and wraps from 0xFFFF to 0.
- FSM states: IDLE, COMMIT, DONE.
  - IDLE -> COMMIT on frame_edge when (pending || auto). pending clears on that same edge and idx resets to 0. Otherwise the FSM stays in IDLE.
  - COMMIT copies slot idx shadow x/y to active, one slot per cycle, idx = 0..NUM_SPRITES-1. On the cycle after the last slot it copies the enable mask, then moves to DONE. Total is NUM_SPRITES+1 cycles in COMMIT.
  - DONE lasts 1 cycle: sets irq if irq_en, then -> IDLE.
  - busy = (state != IDLE).
- Shadow writes are always accepted, including during COMMIT. A slot copied later in the sweep takes whatever its shadow holds at its copy cycle.
- A CTRL commit write during COMMIT/DONE sets pending for the next frame. A commit write while pending is already 1 has no effect.
- A frame_edge while not in IDLE cannot occur in legal timing (a commit takes ≤ 34 cycles against an 800+-cycle line). If it does, it is ignored for committing but still counts.
- If irq set (DONE) and irq clear (0x43 write) occur in the same cycle, set wins.
- Active outputs change only in COMMIT. They are registered and glitch-free.
- Reset mid-commit leaves the active registers all 0; partial copies are discarded.

Test Plan:
- Reset, then read 0x42 -> readdata 0; spr_en=0; irq=0; frame_count=0.
- Write slot0 x=100, y=260 and mask=0x01, without commit, then drive vcount to 480 -> active outputs stay 0, frame_count=1, no COMMIT entered.
- Same writes, then CTRL=0x5, then vcount 479->480 -> busy for 8 cycles (NUM_SPRITES=6). spr_x[0]=100, spr_y[0]=260, spr_en=0x01, irq=1, pending=0. Write 0x43=1 -> irq=0.
- CTRL=0x1, then write slot5 x=500 during COMMIT idx=2 -> active slot5 x=500 the same frame. Write slot0 x=7 during idx=3 -> slot0 keeps its old value until the next commit.
- auto=1, hold vcount at 480 for 3 lines' worth of cycles -> exactly one commit and frame_count +1. Wrap check: 65536 frames -> frame_count=0.
- Assert reset during COMMIT at idx=3 -> all spr_* = 0 and state IDLE immediately (asynchronous). The next committed frame is fully correct.
